des_key_recovery: RTL and testbench

- Receive-side companion to the parallel DES key sweeper. The sweeper issues a base key each cycle to LANES pipelined DES engines and compares their outputs against the known ciphertext.
- This block takes the per-lane match vector back out of the pipeline and realigns it with the base key that produced it. It reconstructs the exact matching 56-bit key and reports it through a valid/ack handshake.
- It also counts hits and flags keyspace exhaustion.
- It sits between the sweeper top level and the display/host logic.

---
 rtl/des_key_recovery.sv | 130 +++++++++++++
 tb/tb_des_key_recovery.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/des_key_recovery.sv
// Realigns per-lane DES match vectors with the base key that produced them,
// reconstructs the matching key and reports it through a valid/ack handshake.
module des_key_recovery #(
    parameter int unsigned LANES   = 28,
    parameter int unsigned LATENCY = 16,
    parameter int unsigned KEY_W   = 56
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    input  logic             start,
    input  logic             issue_valid,
    input  logic [KEY_W-1:0] key_base,
    input  logic [LANES-1:0] lane_match,
    input  logic             result_ack,
    output logic             result_valid,
    output logic [KEY_W-1:0] found_key,
    output logic [4:0]       found_lane,
    output logic [7:0]       hit_count,
    output logic             busy,
    output logic             exhausted
);

    localparam int unsigned LANE_W = 5;
    localparam logic [KEY_W-1:0] LAST_BASE = {KEY_W{1'b1}} - KEY_W'(LANES - 1);

    typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_FOUND, S_DONE} state_t;

    state_t             state_q, state_d;
    logic               dl_v_q [LATENCY];
    logic [KEY_W-1:0]   dl_k_q [LATENCY];

    logic               dv;
    logic [KEY_W-1:0]   dbase;
    logic [LANE_W-1:0]  hit_lane;
    logic [KEY_W:0]     key_sum;
    logic               active, hit, last;

    logic               exh_d, rv_d, busy_d;
    logic [7:0]         hc_d;
    logic [KEY_W-1:0]   fk_d;
    logic [LANE_W-1:0]  fl_d;

    assign dv    = dl_v_q[LATENCY-1];
    assign dbase = dl_k_q[LATENCY-1];

    // Lowest set lane wins.
    always_comb begin
        hit_lane = '0;
        for (int i = int'(LANES) - 1; i >= 0; i--) begin
            if (lane_match[i]) hit_lane = LANE_W'(i);
        end
    end

    // Carry out of the top bit is dropped so the last batch wraps to key 0.
    assign key_sum = {1'b0, dbase} + (KEY_W + 1)'(hit_lane);
    assign active  = (state_q == S_SEARCH) || (state_q == S_FOUND);
    assign hit     = dv && (lane_match != '0) && active && !start;
    assign last    = dv && (dbase >= LAST_BASE) && active && !start;

    always_comb begin
        state_d = state_q;
        exh_d   = exhausted;
        hc_d    = hit_count;
        fk_d    = found_key;
        fl_d    = found_lane;
        if (start) begin
            state_d = S_SEARCH;
            exh_d   = 1'b0;
            hc_d    = '0;
        end else begin
            if (hit && hit_count != 8'hFF) hc_d = hit_count + 8'd1;
            if (last) exh_d = 1'b1;
            case (state_q)
                S_SEARCH: begin
                    if (hit) begin
                        state_d = S_FOUND;
                        fk_d    = key_sum[KEY_W-1:0];
                        fl_d    = hit_lane;
                    end else if (last) begin
                        state_d = S_DONE;
                    end
                end
                S_FOUND: begin
                    if (result_ack) state_d = exh_d ? S_DONE : S_SEARCH;
                end
                default: ;
            endcase
        end
        rv_d   = (state_d == S_FOUND);
        busy_d = (state_d == S_SEARCH) || (state_d == S_FOUND);
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= S_IDLE;
            result_valid <= 1'b0;
            found_key    <= '0;
            found_lane   <= '0;
            hit_count    <= '0;
            busy         <= 1'b0;
            exhausted    <= 1'b0;
        end else begin
            state_q      <= state_d;
            result_valid <= rv_d;
            found_key    <= fk_d;
            found_lane   <= fl_d;
            hit_count    <= hc_d;
            busy         <= busy_d;
            exhausted    <= exh_d;
        end
    end

    // Issue delay line; a start invalidates everything in flight.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < int'(LATENCY); i++) begin
                dl_v_q[i] <= 1'b0;
                dl_k_q[i] <= '0;
            end
        end else begin
            dl_v_q[0] <= issue_valid && !start;
            dl_k_q[0] <= key_base;
            for (int i = 1; i < int'(LATENCY); i++) begin
                dl_v_q[i] <= dl_v_q[i-1] && !start;
                dl_k_q[i] <= dl_k_q[i-1];
            end
        end
    end

endmodule

// File: tb/tb_des_key_recovery.sv
// Bench for des_key_recovery: directed scenarios plus random traffic checked
// cycle by cycle against a history-based reference model.
module tb_des_key_recovery;

    localparam int unsigned LANES   = 28;
    localparam int unsigned LATENCY = 16;
    localparam int unsigned KEY_W   = 56;
    localparam int          HIST    = 4096;
    localparam logic [63:0] TOP     = 64'h0100_0000_0000_0000;
    localparam int M_IDLE = 0, M_SEARCH = 1, M_FOUND = 2, M_DONE = 3;

    logic             CLOCK_50 = 1'b0;
    logic             RESET_N;
    logic             start, issue_valid, result_ack;
    logic [KEY_W-1:0] key_base;
    logic [LANES-1:0] lane_match;
    logic             result_valid, busy, exhausted;
    logic [KEY_W-1:0] found_key;
    logic [4:0]       found_lane;
    logic [7:0]       hit_count;

    always #5 CLOCK_50 = ~CLOCK_50;

    des_key_recovery #(.LANES(LANES), .LATENCY(LATENCY), .KEY_W(KEY_W)) dut (
        .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .start(start),
        .issue_valid(issue_valid), .key_base(key_base), .lane_match(lane_match),
        .result_ack(result_ack), .result_valid(result_valid), .found_key(found_key),
        .found_lane(found_lane), .hit_count(hit_count), .busy(busy), .exhausted(exhausted)
    );

    // Issue history indexed by cycle, and lane_match scheduled per cycle.
    bit               iv_h    [HIST];
    logic [KEY_W-1:0] kb_h    [HIST];
    logic [LANES-1:0] lm_sched[HIST];
    logic [LANES-1:0] lm_or;
    int               cyc, last_clear;

    int          m_state, m_fl, m_hc;
    logic [63:0] m_fk;
    bit          m_exh;
    int          n_cmp, n_bad;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_all();
        check("result_valid", 64'(result_valid), 64'(m_state == M_FOUND));
        check("busy", 64'(busy), 64'(m_state == M_SEARCH || m_state == M_FOUND));
        check("found_key", 64'(found_key), m_fk);
        check("found_lane", 64'(found_lane), 64'(m_fl));
        check("hit_count", 64'(hit_count), 64'(m_hc));
        check("exhausted", 64'(exhausted), 64'(m_exh));
    endtask

    task automatic model_reset(input int c);
        m_state = M_IDLE; m_fk = '0; m_fl = 0; m_hc = 0; m_exh = 1'b0;
        last_clear = c;
    endtask

    // An entry issued at idx reaches the compare point at idx+LATENCY and is
    // live only if no start/reset happened at or after its issue cycle.
    task automatic model_cycle(input bit st, input bit ak, input logic [LANES-1:0] lm);
        int idx, lane;
        bit tv, hit, last;
        logic [63:0] tb;
        logic [LANES-1:0] low;
        idx = cyc - int'(LATENCY);
        tv = 1'b0; tb = '0;
        if (idx >= 0 && idx > last_clear) begin
            tv = iv_h[idx];
            tb = 64'(kb_h[idx]);
        end
        if (st) begin
            m_state = M_SEARCH; m_hc = 0; m_exh = 1'b0; last_clear = cyc;
            return;
        end
        if (m_state == M_IDLE || m_state == M_DONE) return;
        hit  = tv && (lm != '0);
        last = tv && (tb + 64'(LANES) >= TOP);
        low  = lm & (~lm + 1'b1);
        lane = $clog2(low);
        if (hit) m_hc = (m_hc + 1 > 255) ? 255 : m_hc + 1;
        if (last) m_exh = 1'b1;
        if (m_state == M_SEARCH) begin
            if (hit) begin
                m_fk = (tb + 64'(lane)) % TOP;
                m_fl = lane;
                m_state = M_FOUND;
            end else if (last) begin
                m_state = M_DONE;
            end
        end else if (ak) begin
            m_state = m_exh ? M_DONE : M_SEARCH;
        end
    endtask

    task automatic step(input bit st, input bit iv, input logic [KEY_W-1:0] kb, input bit ak);
        if (cyc >= HIST - int'(LATENCY) - 2) begin
            $display("FAIL history: cycle budget %0d exceeded", HIST);
            $fatal(1);
        end
        start = st; issue_valid = iv; key_base = kb; result_ack = ak;
        lane_match = lm_sched[cyc] | lm_or;
        iv_h[cyc] = iv;
        kb_h[cyc] = kb;
        @(posedge CLOCK_50);
        if (!RESET_N) model_reset(cyc);
        else model_cycle(st, ak, lane_match);
        cyc++;
        #1 check_all();
    endtask

    task automatic issue(input logic [KEY_W-1:0] kb, input logic [LANES-1:0] m);
        lm_sched[cyc + int'(LATENCY)] = m;
        step(1'b0, 1'b1, kb, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, '0, 1'b0);
    endtask

    function automatic logic [KEY_W-1:0] rand_key();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[KEY_W-1:0];
    endfunction

    bit               st, iv, ak;
    logic [KEY_W-1:0] kb;
    logic [LANES-1:0] m;

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0; lm_or = '0;
        foreach (lm_sched[i]) lm_sched[i] = '0;
        model_reset(-1);
        start = 0; issue_valid = 0; key_base = '0; result_ack = 0; lane_match = '0;
        RESET_N = 1'b0;
        #1 check_all();

        // Reset held with random inputs, then ignored matches in IDLE.
        lm_or = LANES'($urandom());
        for (int i = 0; i < 4; i++) step(1'($urandom()), 1'b1, rand_key(), 1'($urandom()));
        check("rst_hit_count", 64'(hit_count), 64'd0);
        RESET_N = 1'b1;
        lm_or = '1;
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, rand_key(), 1'b0);
        check("idle_hit_count", 64'(hit_count), 64'd0);
        check("idle_result_valid", 64'(result_valid), 64'd0);
        lm_or = '0;

        // Single hit on the third batch.
        step(1'b1, 1'b0, '0, 1'b0);
        issue(56'h00, '0);
        issue(56'h1C, '0);
        issue(56'h38, LANES'(1) << 5);
        idle(16);
        check("single_valid", 64'(result_valid), 64'd1);
        check("single_key", 64'(found_key), 64'h3D);
        check("single_lane", 64'(found_lane), 64'd5);
        check("single_count", 64'(hit_count), 64'd1);
        step(1'b0, 1'b0, '0, 1'b1);

        // Priority encode and hold while FOUND.
        step(1'b1, 1'b0, '0, 1'b0);
        issue(56'h70, (LANES'(1) << 3) | (LANES'(1) << 9));
        issue(56'h8C, LANES'(1));
        idle(15);
        check("prio_key", 64'(found_key), 64'h73);
        check("prio_lane", 64'(found_lane), 64'd3);
        idle(1);
        check("hold_key", 64'(found_key), 64'h73);
        check("hold_count", 64'(hit_count), 64'd2);
        step(1'b0, 1'b0, '0, 1'b1);
        check("ack_valid", 64'(result_valid), 64'd0);
        check("ack_busy", 64'(busy), 64'd1);

        // Wrapping hit on the last batch.
        issue(56'hFFFFFFFFFFFFF0, LANES'(1) << 20);
        idle(16);
        check("wrap_key", 64'(found_key), 64'h4);
        check("wrap_exhausted", 64'(exhausted), 64'd1);
        step(1'b0, 1'b0, '0, 1'b1);
        check("wrap_done_busy", 64'(busy), 64'd0);

        // Exhaustion with no hit at the exact threshold.
        step(1'b1, 1'b0, '0, 1'b0);
        issue(56'hFFFFFFFFFFFFE4, '0);
        idle(16);
        check("exh_flag", 64'(exhausted), 64'd1);
        check("exh_valid", 64'(result_valid), 64'd0);
        check("exh_busy", 64'(busy), 64'd0);

        // start collides with a hit and an ack.
        step(1'b1, 1'b0, '0, 1'b0);
        issue(56'h100, LANES'(1) << 1);
        issue(56'h200, LANES'(1) << 2);
        idle(15);
        check("coll_found", 64'(result_valid), 64'd1);
        step(1'b1, 1'b0, '0, 1'b1);
        check("coll_valid", 64'(result_valid), 64'd0);
        check("coll_count", 64'(hit_count), 64'd0);
        check("coll_busy", 64'(busy), 64'd1);

        // Asynchronous reset while FOUND.
        issue(56'h300, LANES'(1) << 7);
        idle(16);
        check("pre_rst_valid", 64'(result_valid), 64'd1);
        RESET_N = 1'b0;
        #1;
        model_reset(cyc - 1);
        check_all();
        check("async_key", 64'(found_key), 64'd0);
        step(1'b0, 1'b1, rand_key(), 1'b0);
        step(1'b0, 1'b1, rand_key(), 1'b0);
        RESET_N = 1'b1;

        // hit_count saturation.
        step(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 270; i++) begin
            lm_sched[cyc + int'(LATENCY)] = LANES'(1);
            step(1'b0, 1'b1, KEY_W'(i * 28), 1'($urandom_range(0, 1)));
        end
        idle(16);
        check("sat_count", 64'(hit_count), 64'd255);

        // Random traffic.
        for (int n = 0; n < 1800; n++) begin
            st = ($urandom_range(0, 199) == 0) || (m_state == M_IDLE)
                 || (m_state == M_DONE && $urandom_range(0, 9) == 0);
            iv = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 29) == 0) kb = {KEY_W{1'b1}} - KEY_W'($urandom_range(0, 59));
            else kb = rand_key();
            case ($urandom_range(0, 9))
                0: m = LANES'(1) << $urandom_range(0, LANES - 1);
                1: m = LANES'($urandom());
                default: m = '0;
            endcase
            lm_sched[cyc + int'(LATENCY)] = m;
            ak = ($urandom_range(0, 2) == 0);
            step(st, iv, kb, ak);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
